// File: rtl/udp_echo_app_out_ctrl_pkg.sv
// Shared definitions for the UDP echo app output sequencer: message widths,
// the output flit-mux select encoding and the sequencer state encoding.
package udp_echo_app_out_ctrl_pkg;

  localparam int MSG_LENGTH_WIDTH = 16;
  localparam int NOC_DATA_BYTES_W = 6;

  // The datapath flit mux decodes this same encoding.
  typedef enum logic [1:0] {
    SEL_HDR  = 2'd0,
    SEL_META = 2'd1,
    SEL_DATA = 2'd2
  } out_flit_sel_e;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    HDR_FLIT   = 2'd1,
    META_FLIT  = 2'd2,
    DATA_FLITS = 2'd3
  } out_state_e;

endpackage

// File: rtl/udp_echo_app_out_ctrl.sv
// Output-side sequencer of the UDP echo app: emits header, meta, then payload
// flits onto the NoC and releases the captured header/meta registers at the end.
module udp_echo_app_out_ctrl
  import udp_echo_app_out_ctrl_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        hdr_meta_val,
  output logic                        out_ctrl_hdr_meta_rdy,
  input  logic [MSG_LENGTH_WIDTH-1:0] total_flits,
  input  logic                        data_buf_val,
  output logic                        out_ctrl_data_buf_rdy,
  output logic                        udp_app_out_noc0_vrtoc_val,
  input  logic                        noc0_vrtoc_udp_app_out_rdy,
  output logic [1:0]                  out_flit_sel,
  output logic                        out_busy
);

  out_state_e                  state_reg;
  out_state_e                  state_next;
  out_flit_sel_e               sel;
  logic [MSG_LENGTH_WIDTH-1:0] flit_cnt_reg;
  logic [MSG_LENGTH_WIDTH-1:0] flits_total_reg;
  logic                        cnt_clr;
  logic                        cnt_inc;
  logic                        total_ld;
  logic                        last_flit;

  // A zero-length request would never terminate; treat it as meta only.
  function automatic logic [MSG_LENGTH_WIDTH-1:0] clamp_total(
    input logic [MSG_LENGTH_WIDTH-1:0] len
  );
    return (len == '0) ? MSG_LENGTH_WIDTH'(1) : len;
  endfunction

  assign last_flit = (flit_cnt_reg == flits_total_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      flit_cnt_reg    <= '0;
      flits_total_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (cnt_clr) begin
        flit_cnt_reg <= '0;
      end else if (cnt_inc) begin
        flit_cnt_reg <= flit_cnt_reg + MSG_LENGTH_WIDTH'(1);
      end
      if (total_ld) begin
        flits_total_reg <= clamp_total(total_flits);
      end
    end
  end

  always_comb begin
    state_next                 = state_reg;
    udp_app_out_noc0_vrtoc_val = 1'b0;
    out_ctrl_data_buf_rdy      = 1'b0;
    out_ctrl_hdr_meta_rdy      = 1'b0;
    sel                        = SEL_HDR;
    cnt_clr                    = 1'b0;
    cnt_inc                    = 1'b0;
    total_ld                   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (hdr_meta_val) begin
          total_ld   = 1'b1;
          cnt_clr    = 1'b1;
          state_next = HDR_FLIT;
        end
      end
      HDR_FLIT: begin
        udp_app_out_noc0_vrtoc_val = 1'b1;
        if (noc0_vrtoc_udp_app_out_rdy) begin
          cnt_inc    = 1'b1;
          state_next = META_FLIT;
        end
      end
      META_FLIT: begin
        udp_app_out_noc0_vrtoc_val = 1'b1;
        sel                        = SEL_META;
        if (noc0_vrtoc_udp_app_out_rdy) begin
          if (last_flit) begin
            out_ctrl_hdr_meta_rdy = 1'b1;
            state_next            = IDLE;
          end else begin
            cnt_inc    = 1'b1;
            state_next = DATA_FLITS;
          end
        end
      end
      DATA_FLITS: begin
        // The buffer is popped only in cycles the NoC is ready to take the flit.
        sel                        = SEL_DATA;
        udp_app_out_noc0_vrtoc_val = data_buf_val;
        out_ctrl_data_buf_rdy      = noc0_vrtoc_udp_app_out_rdy;
        if (data_buf_val && noc0_vrtoc_udp_app_out_rdy) begin
          cnt_inc = 1'b1;
          if (last_flit) begin
            out_ctrl_hdr_meta_rdy = 1'b1;
            state_next            = IDLE;
          end
        end
      end
      default: begin
        state_next                 = out_state_e'(2'bxx);
        udp_app_out_noc0_vrtoc_val = 1'bx;
        out_ctrl_data_buf_rdy      = 1'bx;
        out_ctrl_hdr_meta_rdy      = 1'bx;
        sel                        = out_flit_sel_e'(2'bxx);
        cnt_clr                    = 1'bx;
        cnt_inc                    = 1'bx;
        total_ld                   = 1'bx;
      end
    endcase
  end

  assign out_flit_sel = sel;
  assign out_busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_udp_echo_app_out_ctrl.sv
// Directed bench for udp_echo_app_out_ctrl: cycle table plus multi-cycle
// response sequences with bounded loops.
module tb_udp_echo_app_out_ctrl;
  import udp_echo_app_out_ctrl_pkg::*;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        hdr_meta_val;
  logic                        out_ctrl_hdr_meta_rdy;
  logic [MSG_LENGTH_WIDTH-1:0] total_flits;
  logic                        data_buf_val;
  logic                        out_ctrl_data_buf_rdy;
  logic                        udp_app_out_noc0_vrtoc_val;
  logic                        noc0_vrtoc_udp_app_out_rdy;
  logic [1:0]                  out_flit_sel;
  logic                        out_busy;

  int n_checks = 0;
  int n_fail   = 0;

  udp_echo_app_out_ctrl dut (
    .clk                        (clk),
    .rst                        (rst),
    .hdr_meta_val               (hdr_meta_val),
    .out_ctrl_hdr_meta_rdy      (out_ctrl_hdr_meta_rdy),
    .total_flits                (total_flits),
    .data_buf_val               (data_buf_val),
    .out_ctrl_data_buf_rdy      (out_ctrl_data_buf_rdy),
    .udp_app_out_noc0_vrtoc_val (udp_app_out_noc0_vrtoc_val),
    .noc0_vrtoc_udp_app_out_rdy (noc0_vrtoc_udp_app_out_rdy),
    .out_flit_sel               (out_flit_sel),
    .out_busy                   (out_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        hmv;
    logic [15:0] tot;
    logic        dbv;
    logic        rdy;
    logic        e_val;
    logic        e_brdy;
    logic        e_mrdy;
    logic [1:0]  e_sel;
    logic        e_busy;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic h, input int t, input logic d, input logic y,
                     input logic ev, input logic eb, input logic em, input int es, input logic ebz);
    vec_t v;
    v.rst = r; v.hmv = h; v.tot = 16'(t); v.dbv = d; v.rdy = y;
    v.e_val = ev; v.e_brdy = eb; v.e_mrdy = em; v.e_sel = 2'(es); v.e_busy = ebz;
    vecs.push_back(v);
  endtask

  // Starts from IDLE at posedge+1; runs one response and counts what the NoC sees.
  task automatic run_resp(input int tot, input int tot_late, input bit tgl,
                          input int gs, input int gl,
                          output int nflits, output int npops, output int ndata,
                          output int nrel, output bit sel_ok);
    bit done;
    logic [1:0] exp_sel;
    nflits = 0; npops = 0; ndata = 0; nrel = 0; sel_ok = 1'b1; done = 1'b0;
    hdr_meta_val = 1'b1;
    total_flits  = 16'(tot);
    for (int c = 0; c < 100 && !done; c++) begin
      if (c == 1) hdr_meta_val = 1'b0;
      if (c >= 4) total_flits = 16'(tot_late);
      noc0_vrtoc_udp_app_out_rdy = tgl ? (c % 2 == 1) : 1'b1;
      data_buf_val = (c >= gs && c < gs + gl) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (udp_app_out_noc0_vrtoc_val && noc0_vrtoc_udp_app_out_rdy) begin
        exp_sel = (nflits == 0) ? SEL_HDR : (nflits == 1) ? SEL_META : SEL_DATA;
        if (out_flit_sel != exp_sel) sel_ok = 1'b0;
        if (nflits >= 2) ndata++;
        nflits++;
      end
      if (data_buf_val && out_ctrl_data_buf_rdy) npops++;
      if (out_ctrl_hdr_meta_rdy) begin
        nrel++;
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    noc0_vrtoc_udp_app_out_rdy = 1'b1;
    data_buf_val = 1'b1;
  endtask

  initial begin
    int nf, np, nd, nr;
    bit sok;
    logic [6:0] val_seq;
    int rel_cnt;

    rst = 1'b1; hdr_meta_val = 1'b0; total_flits = '0;
    data_buf_val = 1'b0; noc0_vrtoc_udp_app_out_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    add(0,0,0,0,0, 0,0,0,0,0);
    // total_flits=3, full throughput
    add(0,1,3,1,1, 0,0,0,0,0);
    add(0,0,3,1,1, 1,0,0,0,1);
    add(0,0,3,1,1, 1,0,0,1,1);
    add(0,0,3,1,1, 1,1,0,2,1);
    add(0,0,3,1,1, 1,1,1,2,1);
    add(0,0,3,1,1, 0,0,0,0,0);
    // total_flits=1: header and meta only
    add(0,1,1,1,1, 0,0,0,0,0);
    add(0,0,1,1,1, 1,0,0,0,1);
    add(0,0,1,1,1, 1,0,1,1,1);
    add(0,0,1,1,1, 0,0,0,0,0);
    // total_flits=0 behaves like 1
    add(0,1,0,1,1, 0,0,0,0,0);
    add(0,0,0,1,1, 1,0,0,0,1);
    add(0,0,0,1,1, 1,0,1,1,1);
    add(0,0,0,1,1, 0,0,0,0,0);
    // total_flits=2 with NoC stalls and a buffer bubble
    add(0,1,2,1,1, 0,0,0,0,0);
    add(0,0,2,1,0, 1,0,0,0,1);
    add(0,0,2,1,1, 1,0,0,0,1);
    add(0,0,2,1,0, 1,0,0,1,1);
    add(0,0,2,1,1, 1,0,0,1,1);
    add(0,0,2,1,0, 1,0,0,2,1);
    add(0,0,2,0,1, 0,1,0,2,1);
    add(0,0,2,1,1, 1,1,1,2,1);
    add(0,0,2,1,1, 0,0,0,0,0);
    // rst on the 2nd data flit of a total_flits=6 response
    add(0,1,6,1,1, 0,0,0,0,0);
    add(0,0,6,1,1, 1,0,0,0,1);
    add(0,0,6,1,1, 1,0,0,1,1);
    add(0,0,6,1,1, 1,1,0,2,1);
    add(1,0,6,1,1, 1,1,0,2,1);
    add(0,0,6,1,1, 0,0,0,0,0);
    // fresh total_flits=2 response after the reset
    add(0,1,2,1,1, 0,0,0,0,0);
    add(0,0,2,1,1, 1,0,0,0,1);
    add(0,0,2,1,1, 1,0,0,1,1);
    add(0,0,2,1,1, 1,1,1,2,1);
    add(0,0,2,1,1, 0,0,0,0,0);

    foreach (vecs[i]) begin
      rst                        = vecs[i].rst;
      hdr_meta_val               = vecs[i].hmv;
      total_flits                = vecs[i].tot;
      data_buf_val               = vecs[i].dbv;
      noc0_vrtoc_udp_app_out_rdy = vecs[i].rdy;
      @(negedge clk);
      check($sformatf("v%0d_val", i),  32'(udp_app_out_noc0_vrtoc_val), 32'(vecs[i].e_val));
      check($sformatf("v%0d_brdy", i), 32'(out_ctrl_data_buf_rdy),      32'(vecs[i].e_brdy));
      check($sformatf("v%0d_mrdy", i), 32'(out_ctrl_hdr_meta_rdy),      32'(vecs[i].e_mrdy));
      check($sformatf("v%0d_sel", i),  32'(out_flit_sel),               32'(vecs[i].e_sel));
      check($sformatf("v%0d_busy", i), 32'(out_busy),                   32'(vecs[i].e_busy));
      @(posedge clk); #1;
    end
    rst = 1'b0;

    // total_flits=4, NoC rdy toggling, buffer empty for 3 cycles mid-payload
    run_resp(4, 4, 1'b1, 4, 3, nf, np, nd, nr, sok);
    check("tgl_flits", 32'(nf), 32'd5);
    check("tgl_pops",  32'(np), 32'd3);
    check("tgl_data_eq_pops", 32'(nd), 32'(np));
    check("tgl_rel",   32'(nr), 32'd1);
    check("tgl_sel_order", 32'(sok), 32'd1);

    // total_flits changes 5 -> 2 mid-payload; latched length wins
    run_resp(5, 2, 1'b0, 100, 0, nf, np, nd, nr, sok);
    check("latch_flits", 32'(nf), 32'd6);
    check("latch_pops",  32'(np), 32'd4);
    check("latch_rel",   32'(nr), 32'd1);
    check("latch_sel_order", 32'(sok), 32'd1);
    @(negedge clk);
    check("latch_idle_after", 32'(out_busy), 32'd0);
    @(posedge clk); #1;

    // back-to-back total_flits=1 responses with hdr_meta_val held high
    val_seq = '0; rel_cnt = 0;
    hdr_meta_val = 1'b1; total_flits = 16'd1;
    noc0_vrtoc_udp_app_out_rdy = 1'b1; data_buf_val = 1'b1;
    for (int c = 0; c < 7; c++) begin
      if (c == 5) hdr_meta_val = 1'b0;
      @(negedge clk);
      val_seq[c] = udp_app_out_noc0_vrtoc_val;
      if (out_ctrl_hdr_meta_rdy) rel_cnt++;
      @(posedge clk); #1;
    end
    check("b2b_val_seq", 32'(val_seq), 32'b0110110);
    check("b2b_rel", 32'(rel_cnt), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
